// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute,
// stalling on mem_ready and trapping on illegal opcodes or memory timeouts.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             branch_ne,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op,
  output logic             bus_error
);

  localparam bit TO_EN = MEM_TIMEOUT > 0;
  localparam int WW =
    TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_LAST =
    TO_EN ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TO_LAST);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    RESET_S,
    FETCH,
    DECODE,
    EXECUTE,
    ALU_WB,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    BRANCH,
    JUMP,
    ADDI_EXEC,
    ADDI_WB,
    TRAP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wait_cnt;
  logic          in_mem;
  logic          timeout;
  logic          set_ill;
  logic          set_berr;

  assign in_mem = (state == FETCH) ||
                  (state == MEM_READ) ||
                  (state == MEM_WRITE);

  // ready in the same cycle always wins over the timeout
  assign timeout = TO_EN && in_mem && !mem_ready &&
                   (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_S;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        wait_cnt <= '0;
      else if (in_mem && !mem_ready)
        wait_cnt <= wait_cnt + WW'(1);
      if (instr_retired)
        instr_count <= instr_count + CNT_W'(1);
      if (set_ill)
        illegal_op <= 1'b1;
      if (set_berr)
        bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    unique case (state)
      RESET_S: state_nx = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_nx = DECODE;
        end else if (timeout) begin
          state_nx = TRAP;
          set_berr = 1'b1;
        end
      end
      DECODE: begin
        unique case (1'b1)
          opcode == OP_R:
            state_nx = EXECUTE;
          opcode == OP_LW,
          opcode == OP_SW:
            state_nx = MEM_ADDR;
          opcode == OP_BEQ,
          opcode == OP_BNE:
            state_nx = BRANCH;
          opcode == OP_J:
            state_nx = JUMP;
          ENABLE_ADDI && (opcode == OP_ADDI):
            state_nx = ADDI_EXEC;
          default: begin
            state_nx = TRAP;
            set_ill  = 1'b1;
          end
        endcase
      end
      EXECUTE: state_nx = ALU_WB;
      ALU_WB:  state_nx = FETCH;
      MEM_ADDR: begin
        if (opcode == OP_LW)
          state_nx = MEM_READ;
        else
          state_nx = MEM_WRITE;
      end
      MEM_READ, MEM_WRITE: begin
        if (mem_ready) begin
          state_nx = (state == MEM_READ) ? MEM_WB : FETCH;
        end else if (timeout) begin
          state_nx = TRAP;
          set_berr = 1'b1;
        end
      end
      MEM_WB:    state_nx = FETCH;
      BRANCH:    state_nx = FETCH;
      JUMP:      state_nx = FETCH;
      ADDI_EXEC: state_nx = ADDI_WB;
      ADDI_WB:   state_nx = FETCH;
      TRAP:      state_nx = TRAP;
      default:   state_nx = RESET_S;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    branch_ne     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_retired = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALU_WB: begin
        reg_dst       = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      MEM_ADDR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg    = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      MEM_WRITE: begin
        mem_write     = 1'b1;
        i_or_d        = 1'b1;
        instr_retired = mem_ready;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        instr_retired = 1'b1;
      end
      JUMP: begin
        pc_write      = 1'b1;
        pc_source     = 2'b10;
        instr_retired = 1'b1;
      end
      ADDI_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench: two controllers (addi on/off) on shared stimulus, checked each
// cycle against an instruction-level phase-plan model.
module tb_multicycle_control_unit;

  localparam int TO = 4;
  localparam int CW = 2;

  typedef enum int {
    P_RST, P_F, P_D, P_EX, P_AWB, P_MA, P_MR,
    P_MWB, P_MW, P_BR, P_J, P_AE, P_AWB2, P_TRAP
  } ph_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;

  logic [17:0]   ctl_o [2];
  logic [CW-1:0] cnt_o [2];
  logic          ill_o [2];
  logic          berr_o [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] op_q [$];
  bit         rdy_q [$];

  ph_t cur [2];
  ph_t body [2][3];
  int  blen [2];
  int  bidx [2];
  int  waits [2];
  int  cnt [2];
  bit  ill [2];
  bit  berr [2];
  bit  fresh [2];
  int  trap_cyc [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pw, pwc, irw, iod, mr, mw, rd, m2r, rw, asa, bne, ret;
    logic [1:0] asb, aop, psrc;
    logic [CW-1:0] cnt;
    logic ill, berr;
    multicycle_control_unit #(
      .MEM_TIMEOUT(TO),
      .ENABLE_ADDI(g == 0),
      .CNT_W(CW)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .opcode(opcode),
      .mem_ready(mem_ready),
      .pc_write(pw),
      .pc_write_cond(pwc),
      .ir_write(irw),
      .i_or_d(iod),
      .mem_read(mr),
      .mem_write(mw),
      .reg_dst(rd),
      .mem_to_reg(m2r),
      .reg_write(rw),
      .alu_src_a(asa),
      .branch_ne(bne),
      .alu_src_b(asb),
      .alu_op(aop),
      .pc_source(psrc),
      .instr_retired(ret),
      .instr_count(cnt),
      .illegal_op(ill),
      .bus_error(berr)
    );
    assign ctl_o[g] = {pw, pwc, irw, iod, mr, mw, rd, m2r,
                       rw, asa, bne, asb, aop, psrc, ret};
    assign cnt_o[g]  = cnt;
    assign ill_o[g]  = ill;
    assign berr_o[g] = berr;
  end

  // expected control word for one phase, straight from the control table
  function automatic logic [17:0] ctl(ph_t p, logic r,
                                      logic [5:0] op);
    logic pw, pwc, irw, iod, mr, mw, rd, m2r, rw, asa, bne, ret;
    logic [1:0] asb, aop, psrc;
    pw = 0; pwc = 0; irw = 0; iod = 0; mr = 0; mw = 0;
    rd = 0; m2r = 0; rw = 0; asa = 0; bne = 0; ret = 0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (p)
      P_F:    begin mr = 1; asb = 2'b01; irw = r; pw = r; end
      P_D:    asb = 2'b11;
      P_EX:   begin asa = 1; aop = 2'b10; end
      P_AWB:  begin rd = 1; rw = 1; ret = 1; end
      P_MA:   begin asa = 1; asb = 2'b10; end
      P_MR:   begin mr = 1; iod = 1; end
      P_MWB:  begin m2r = 1; rw = 1; ret = 1; end
      P_MW:   begin mw = 1; iod = 1; ret = r; end
      P_BR: begin
        asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01;
        bne = (op == 6'b000101); ret = 1;
      end
      P_J:    begin pw = 1; psrc = 2'b10; ret = 1; end
      P_AE:   begin asa = 1; asb = 2'b10; end
      P_AWB2: begin rw = 1; ret = 1; end
      default: ;
    endcase
    return {pw, pwc, irw, iod, mr, mw, rd, m2r,
            rw, asa, bne, asb, aop, psrc, ret};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [7];
    tbl = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08};
    if (op_q.size() > 0) return op_q.pop_front();
    if ($urandom_range(0, 19) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 6)];
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check(int l, logic r);
    logic [31:0] m;
    m = (32'd1 << CW) - 1;
    chk($sformatf("ctl[%0d]", l), 32'(ctl_o[l]),
        32'(ctl(cur[l], r, opcode)));
    chk($sformatf("count[%0d]", l), 32'(cnt_o[l]),
        32'(cnt[l]) & m);
    chk($sformatf("illegal[%0d]", l), 32'(ill_o[l]),
        32'(ill[l]));
    chk($sformatf("buserr[%0d]", l), 32'(berr_o[l]),
        32'(berr[l]));
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      cur[l] = P_RST; blen[l] = 0; bidx[l] = 0;
      waits[l] = 0; cnt[l] = 0; ill[l] = 0; berr[l] = 0;
      fresh[l] = 0; trap_cyc[l] = 0;
    end
  endtask

  task automatic set_body(int l, ph_t a, ph_t b, ph_t c, int n);
    body[l][0] = a; body[l][1] = b; body[l][2] = c;
    blen[l] = n;
  endtask

  task automatic plan(int l);
    case (opcode)
      6'b000000: set_body(l, P_EX, P_AWB, P_RST, 2);
      6'b100011: set_body(l, P_MA, P_MR, P_MWB, 3);
      6'b101011: set_body(l, P_MA, P_MW, P_RST, 2);
      6'b000100,
      6'b000101: set_body(l, P_BR, P_RST, P_RST, 1);
      6'b000010: set_body(l, P_J, P_RST, P_RST, 1);
      6'b001000:
        if (l == 0) set_body(l, P_AE, P_AWB2, P_RST, 2);
        else        set_body(l, P_TRAP, P_RST, P_RST, 1);
      default: set_body(l, P_TRAP, P_RST, P_RST, 1);
    endcase
  endtask

  task automatic enter_fetch(int l);
    cur[l] = P_F;
    waits[l] = 0;
    fresh[l] = 1;
  endtask

  task automatic advance(int l, logic r);
    logic [17:0] e;
    bit memph;
    e = ctl(cur[l], r, opcode);
    memph = cur[l] inside {P_F, P_MR, P_MW};
    if (e[0]) cnt[l]++;
    if (cur[l] == P_TRAP) begin trap_cyc[l]++; return; end
    if (cur[l] == P_RST) begin enter_fetch(l); return; end
    if (memph && !r) begin
      waits[l]++;
      if (waits[l] == TO) begin
        cur[l] = P_TRAP;
        berr[l] = 1;
      end
      return;
    end
    waits[l] = 0;
    if (cur[l] == P_F) begin cur[l] = P_D; return; end
    if (cur[l] == P_D) begin
      plan(l);
      bidx[l] = 0;
      cur[l] = body[l][0];
      if (cur[l] == P_TRAP) ill[l] = 1;
      return;
    end
    bidx[l]++;
    if (bidx[l] >= blen[l]) enter_fetch(l);
    else cur[l] = body[l][bidx[l]];
  endtask

  // one clock cycle: entered and left at posedge + 1
  task automatic cycle();
    logic r;
    if (fresh[0] || fresh[1]) begin
      opcode = pick_op();
      fresh[0] = 0;
      fresh[1] = 0;
    end
    if (rdy_q.size() > 0) r = rdy_q.pop_front();
    else r = ($urandom_range(0, 99) < 85);
    mem_ready = r;
    @(negedge clk);
    for (int l = 0; l < 2; l++) check(l, r);
    for (int l = 0; l < 2; l++) advance(l, r);
    @(posedge clk);
    #1;
  endtask

  // reset asserted between edges; outputs must clear at once
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int l = 0; l < 2; l++) check(l, mem_ready);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_rdy(int n, bit v);
    repeat (n) rdy_q.push_back(v);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) check(l, mem_ready);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // R, lw with stalls, bne, beq, five jumps, sw timeout
    op_q.push_back(6'b000000);
    op_q.push_back(6'b100011);
    op_q.push_back(6'b000101);
    op_q.push_back(6'b000100);
    repeat (5) op_q.push_back(6'b000010);
    op_q.push_back(6'b101011);
    push_rdy(5, 1);
    push_rdy(2, 0); push_rdy(3, 1);
    push_rdy(2, 0); push_rdy(2, 1);
    push_rdy(21, 1);
    push_rdy(3, 1); push_rdy(4, 0);
    push_rdy(10, 1);
    repeat (52) cycle();
    do_reset();

    // sw ready on the last allowed cycle, then illegal opcode
    op_q.push_back(6'b101011);
    op_q.push_back(6'b111111);
    push_rdy(4, 1); push_rdy(3, 0); push_rdy(1, 1);
    push_rdy(12, 0);
    repeat (20) cycle();
    do_reset();

    // addi: legal in lane 0, illegal in lane 1
    op_q.push_back(6'b001000);
    op_q.push_back(6'b000000);
    repeat (16) cycle();
    do_reset();

    // lw abandoned by reset while stalled in the read
    op_q.push_back(6'b100011);
    push_rdy(4, 1); push_rdy(3, 0);
    repeat (6) cycle();
    do_reset();
    repeat (4) cycle();

    repeat (3000) begin
      if (trap_cyc[0] >= 12 || trap_cyc[1] >= 12 ||
          $urandom_range(0, 399) == 0)
        do_reset();
      else
        cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Moore-style FSM controller for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and emits per-state datapath controls.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeouts.
- Counts retired instructions; sits between the instruction register opcode field and the shared-memory multicycle datapath.

## Interface
- MEM_TIMEOUT, 15, max consecutive wait cycles in a memory state before bus error; 0 disables timeout
- ENABLE_ADDI, 1, 1 = decode addi (6'b001000); 0 = addi is illegal
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock; everything on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26]; held stable by datapath from the cycle after an IR write
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write  out  1 each  datapath strobes/selects
- reg_dst, mem_to_reg, reg_write, alu_src_a, branch_ne  out  1 each  datapath selects/strobes
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- instr_retired  out  1  one-cycle pulse at final cycle of each instruction
- instr_count  out  CNT_W  retired count; wraps modulo 2^CNT_W
- illegal_op, bus_error  out  1 each  sticky trap causes

## Operation
- States: RESET_S, FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP.
- Any output not listed for a state is 0.
- Reset values: state RESET_S, all outputs 0, instr_count 0, wait counter 0.
- RESET_S: always goes to FETCH on the next edge.
- FETCH: mem_read=1, alu_src_b=01.
  - ir_write=1 and pc_write=1 only in a cycle with mem_ready=1; that cycle exits to DECODE.
  - Otherwise waits in FETCH.
- DECODE: alu_src_b=11. Next state from opcode:
  - 000000 → EXECUTE
  - 100011/101011 → MEM_ADDR
  - 000100/000101 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC if ENABLE_ADDI=1, else TRAP with illegal_op set
  - anything else → TRAP, illegal_op=1
- EXECUTE: alu_src_a=1, alu_op=10 → ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, retire → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10 → MEM_READ if opcode=100011, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; waits for mem_ready → MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, retire → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; retires in the mem_ready cycle → FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101); retire → FETCH.
- JUMP: pc_write=1, pc_source=10; retire → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10 → ADDI_WB.
- ADDI_WB: reg_write=1, retire → FETCH.
- TRAP: all controls 0, instr_retired 0; held until rst_n low. illegal_op and bus_error stay set until reset.
- Wait counter (width $clog2(MEM_TIMEOUT+1)):
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - If it equals MEM_TIMEOUT-1 with mem_ready=0 (MEM_TIMEOUT>0): next state TRAP, bus_error=1.
  - mem_ready=1 in the same cycle wins over timeout.

## Timing
- With mem_ready tied high, cycles per instruction: R 4, lw 5, sw 4, beq/bne 3, j 3, addi 4.
- Each memory wait cycle adds one cycle to the owning state.
- Outputs are decoded from the registered state. Only ir_write, pc_write (FETCH) and instr_retired (MEM_WRITE) are qualified combinationally by mem_ready.
- instr_count increments on the edge ending any cycle where instr_retired=1.
- rst_n low at any time: state and all outputs go to reset values immediately, with no clock edge needed. Any in-flight instruction is abandoned and not counted.
- Trap entry takes effect on the edge ending the DECODE or timeout cycle. TRAP outputs are visible the following cycle.

## Test plan
- Reset, then R-type 000000 with mem_ready=1: state sequence RESET_S, FETCH, DECODE, EXECUTE, ALU_WB; reg_dst=reg_write=1 in ALU_WB; instr_retired pulses once; instr_count=1.
- lw 100011 with mem_ready low 2 cycles in FETCH and 2 in MEM_READ: 9 cycles FETCH→MEM_WB; mem_to_reg=1 only in MEM_WB; no timeout.
- bne 000101: BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01, branch_ne=1. beq 000100 gives the same outputs with branch_ne=0.
- opcode 111111, and addi with ENABLE_ADDI=0: TRAP after DECODE; illegal_op=1; all controls 0 for 10 further cycles; instr_count unchanged.
- MEM_TIMEOUT=4, sw with mem_ready held 0: 4 cycles in MEM_WRITE, then TRAP with bus_error=1. Repeat with mem_ready=1 on the 4th cycle: normal retire, bus_error stays 0.
- CNT_W=2: 5 JUMPs give instr_count 1,2,3,0,1. Assert rst_n mid-MEM_READ: outputs 0 asynchronously, count 0, restart from FETCH.
